// File: rtl/nist_health_monitor.sv
// rtl/nist_health_monitor.sv - entropy health verdict built from NIST test error flags
// Warm-up blanking, sticky per-test flags, burst failure window and saturating tally.
module nist_health_monitor #(
  parameter int N_TESTS       = 4,
  parameter int CNT_W         = 8,
  parameter int WARMUP_CYCLES = 1024,
  parameter int WINDOW        = 4096,
  parameter int FAIL_THRESH   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_TESTS-1:0] err_in,
  input  logic               clear,
  output logic               health_ok,
  output logic               alarm,
  output logic [1:0]         state,
  output logic [N_TESTS-1:0] sticky,
  output logic [CNT_W-1:0]   fail_total
);
  localparam int EV_W  = $clog2(N_TESTS + 1);
  localparam int WF_W  = $clog2(FAIL_THRESH + N_TESTS + 1);
  localparam int WU_W  = $clog2(WARMUP_CYCLES + 1);
  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int SUM_W = CNT_W + EV_W;

  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WF_W-1:0]  THRESH   = WF_W'(FAIL_THRESH);
  localparam logic [SUM_W-1:0] FT_MAX   = SUM_W'({CNT_W{1'b1}});

  typedef enum logic [1:0] {
    ST_WARMUP   = 2'b00,
    ST_HEALTHY  = 2'b01,
    ST_DEGRADED = 2'b10,
    ST_FAILED   = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [N_TESTS-1:0] err_q, err_d;
  logic [N_TESTS-1:0] err_dly_q, err_dly_d;
  logic [N_TESTS-1:0] ev_q, ev_d;
  logic [WU_W-1:0]    warm_q, warm_d;
  logic [WIN_W-1:0]   win_timer_q, win_timer_d;
  logic [WF_W-1:0]    win_fails_q, win_fails_d;
  logic [N_TESTS-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]   fail_total_q, fail_total_d;
  logic               health_ok_q, health_ok_d;
  logic               alarm_q, alarm_d;

  logic [EV_W-1:0]    ev_n;
  logic [WF_W-1:0]    ev_w;
  logic [WF_W-1:0]    wsum;
  logic [SUM_W-1:0]   ft_sum;

  always_comb begin
    err_d       = err_in;
    err_dly_d   = err_q;
    ev_d        = err_q & ~err_dly_q;
    state_d     = state_q;
    warm_d      = warm_q;
    win_timer_d = win_timer_q;
    win_fails_d = win_fails_q;
    sticky_d    = sticky_q;
    fail_total_d = fail_total_q;

    ev_n = '0;
    for (int i = 0; i < N_TESTS; i++) begin
      ev_n = ev_n + EV_W'(ev_q[i]);
    end
    ev_w   = WF_W'(ev_n);
    wsum   = win_fails_q + ev_w;
    ft_sum = SUM_W'(fail_total_q) + SUM_W'(ev_n);

    case (state_q)
      ST_WARMUP: begin
        if (warm_q == WU_LAST) begin
          state_d = ST_HEALTHY;
          warm_d  = '0;
        end else begin
          warm_d = warm_q + WU_W'(1);
        end
      end
      ST_HEALTHY: begin
        if (ev_n != '0) begin
          sticky_d    = sticky_q | ev_q;
          win_fails_d = ev_w;
          win_timer_d = '0;
          state_d     = (ev_w >= THRESH) ? ST_FAILED : ST_DEGRADED;
        end
      end
      ST_DEGRADED: begin
        sticky_d    = sticky_q | ev_q;
        win_timer_d = win_timer_q + WIN_W'(1);
        // The event is folded in before expiry is considered, so FAILED wins a tie.
        if (wsum >= THRESH) begin
          state_d     = ST_FAILED;
          win_fails_d = THRESH;
        end else if (win_timer_q == WIN_LAST) begin
          state_d     = ST_HEALTHY;
          win_fails_d = '0;
        end else begin
          win_fails_d = wsum;
        end
      end
      ST_FAILED: begin
        sticky_d = sticky_q | ev_q;
        if (clear) begin
          state_d     = ST_WARMUP;
          warm_d      = '0;
          win_fails_d = '0;
        end
      end
      default: begin
        state_d     = ST_WARMUP;
        warm_d      = '0;
        win_fails_d = '0;
      end
    endcase

    if (state_q != ST_WARMUP) begin
      fail_total_d = (ft_sum > FT_MAX) ? {CNT_W{1'b1}} : ft_sum[CNT_W-1:0];
    end
    if (clear) begin
      sticky_d = '0;
    end

    health_ok_d = (state_d == ST_HEALTHY);
    alarm_d     = (state_d == ST_FAILED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_WARMUP;
      err_q        <= '0;
      err_dly_q    <= '0;
      ev_q         <= '0;
      warm_q       <= '0;
      win_timer_q  <= '0;
      win_fails_q  <= '0;
      sticky_q     <= '0;
      fail_total_q <= '0;
      health_ok_q  <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      err_dly_q    <= err_dly_d;
      ev_q         <= ev_d;
      warm_q       <= warm_d;
      win_timer_q  <= win_timer_d;
      win_fails_q  <= win_fails_d;
      sticky_q     <= sticky_d;
      fail_total_q <= fail_total_d;
      health_ok_q  <= health_ok_d;
      alarm_q      <= alarm_d;
    end
  end

  assign state      = state_q;
  assign health_ok  = health_ok_q;
  assign alarm      = alarm_q;
  assign sticky     = sticky_q;
  assign fail_total = fail_total_q;

endmodule

// File: tb/tb_nist_health_monitor.sv
// tb/tb_nist_health_monitor.sv - scoreboard bench for nist_health_monitor
// Small-parameter build: warm-up 16, window 32, threshold 3, 4-bit tally.
module tb_nist_health_monitor;
  typedef struct packed {
    logic [1:0] st;
    logic       hok;
    logic       alm;
    logic [3:0] stk;
    logic [3:0] ft;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [3:0] err_in;
  logic       health_ok;
  logic       alarm;
  logic [1:0] state;
  logic [3:0] sticky;
  logic [3:0] fail_total;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t obs;
  exp_t want;

  nist_health_monitor #(
    .N_TESTS(4), .CNT_W(4), .WARMUP_CYCLES(16), .WINDOW(32), .FAIL_THRESH(3)
  ) dut (
    .clk(clk), .rst(rst), .err_in(err_in), .clear(clear),
    .health_ok(health_ok), .alarm(alarm), .state(state),
    .sticky(sticky), .fail_total(fail_total)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] st, input logic [3:0] stk, input logic [3:0] ft);
    exp_t r;
    r.st  = st;
    r.hok = (st == 2'b01);
    r.alm = (st == 2'b11);
    r.stk = stk;
    r.ft  = ft;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_to_healthy();
    rst = 1'b1; err_in = 4'h0; clear = 1'b0;
    cycle();
    rst = 1'b0;
    repeat (16) cycle();
  endtask

  task automatic test_reset();
    for (int j = 0; j < 20; j++) begin
      rst = (j == 0); err_in = 4'h0; clear = 1'b0;
      sb.push_back(mk((j < 16) ? 2'b00 : 2'b01, 4'h0, 4'h0));
      cycle();
      obs = {state, health_ok, alarm, sticky, fail_total};
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL reset j=%0d got st=%b ok=%b al=%b stk=%b ft=%0d required st=%b ok=%b al=%b stk=%b ft=%0d",
                 j, obs.st, obs.hok, obs.alm, obs.stk, obs.ft, want.st, want.hok, want.alm, want.stk, want.ft);
      end
    end
  endtask

  task automatic test_warmup_ignore();
    for (int j = 0; j < 21; j++) begin
      rst = (j == 0); clear = 1'b0;
      err_in = (j == 5) ? 4'b0010 : 4'b0000;
      sb.push_back(mk((j < 16) ? 2'b00 : 2'b01, 4'h0, 4'h0));
      cycle();
      obs = {state, health_ok, alarm, sticky, fail_total};
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL warmup_ignore j=%0d got st=%b ok=%b al=%b stk=%b ft=%0d required st=%b ok=%b al=%b stk=%b ft=%0d",
                 j, obs.st, obs.hok, obs.alm, obs.stk, obs.ft, want.st, want.hok, want.alm, want.stk, want.ft);
      end
    end
  endtask

  task automatic test_degraded_window();
    logic [1:0] st;
    for (int j = 0; j < 36; j++) begin
      rst = 1'b0; clear = 1'b0;
      err_in = (j == 0) ? 4'b0001 : 4'b0000;
      if (j < 2) st = 2'b01; else if (j < 34) st = 2'b10; else st = 2'b01;
      sb.push_back(mk(st, (j >= 2) ? 4'b0001 : 4'b0000, (j >= 2) ? 4'd1 : 4'd0));
      cycle();
      obs = {state, health_ok, alarm, sticky, fail_total};
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL degraded_window j=%0d got st=%b ok=%b al=%b stk=%b ft=%0d required st=%b ok=%b al=%b stk=%b ft=%0d",
                 j, obs.st, obs.hok, obs.alm, obs.stk, obs.ft, want.st, want.hok, want.alm, want.stk, want.ft);
      end
    end
  endtask

  task automatic test_expiry_coincide();
    logic [1:0] st;
    logic [3:0] stk;
    logic [3:0] ft;
    reset_to_healthy();
    for (int j = 0; j < 38; j++) begin
      rst = 1'b0;
      clear = (j == 10);
      err_in = (j == 0) ? 4'b0011 : ((j == 32) ? 4'b0100 : 4'b0000);
      if (j < 2) st = 2'b01; else if (j < 34) st = 2'b10; else st = 2'b11;
      if (j < 2) stk = 4'b0000; else if (j < 10) stk = 4'b0011; else if (j < 34) stk = 4'b0000; else stk = 4'b0100;
      if (j < 2) ft = 4'd0; else if (j < 34) ft = 4'd2; else ft = 4'd3;
      sb.push_back(mk(st, stk, ft));
      cycle();
      obs = {state, health_ok, alarm, sticky, fail_total};
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL expiry_coincide j=%0d got st=%b ok=%b al=%b stk=%b ft=%0d required st=%b ok=%b al=%b stk=%b ft=%0d",
                 j, obs.st, obs.hok, obs.alm, obs.stk, obs.ft, want.st, want.hok, want.alm, want.stk, want.ft);
      end
    end
  endtask

  task automatic test_failed_direct();
    reset_to_healthy();
    for (int j = 0; j < 6; j++) begin
      rst = 1'b0; clear = 1'b0;
      err_in = (j == 0) ? 4'b0111 : 4'b0000;
      sb.push_back(mk((j < 2) ? 2'b01 : 2'b11, (j < 2) ? 4'b0000 : 4'b0111, (j < 2) ? 4'd0 : 4'd3));
      cycle();
      obs = {state, health_ok, alarm, sticky, fail_total};
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL failed_direct j=%0d got st=%b ok=%b al=%b stk=%b ft=%0d required st=%b ok=%b al=%b stk=%b ft=%0d",
                 j, obs.st, obs.hok, obs.alm, obs.stk, obs.ft, want.st, want.hok, want.alm, want.stk, want.ft);
      end
    end
  endtask

  task automatic test_clear_failed();
    for (int j = 0; j < 19; j++) begin
      rst = 1'b0; err_in = 4'h0;
      clear = (j == 0);
      sb.push_back(mk((j < 16) ? 2'b00 : 2'b01, 4'b0000, 4'd3));
      cycle();
      obs = {state, health_ok, alarm, sticky, fail_total};
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL clear_failed j=%0d got st=%b ok=%b al=%b stk=%b ft=%0d required st=%b ok=%b al=%b stk=%b ft=%0d",
                 j, obs.st, obs.hok, obs.alm, obs.stk, obs.ft, want.st, want.hok, want.alm, want.stk, want.ft);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [1:0] st;
    logic [3:0] stk;
    logic [3:0] ft;
    for (int j = 0; j < 15; j++) begin
      rst = 1'b0; clear = 1'b0;
      err_in = ((j == 0) ? 4'b0001 : 4'b0000) |
               ((j >= 5 && j <= 7) ? 4'b0010 : 4'b0000) |
               ((j == 10) ? 4'b0100 : 4'b0000);
      if (j < 2) st = 2'b01; else if (j < 12) st = 2'b10; else st = 2'b11;
      if (j < 2) stk = 4'b0000; else if (j < 7) stk = 4'b0001; else if (j < 12) stk = 4'b0011; else stk = 4'b0111;
      if (j < 2) ft = 4'd3; else if (j < 7) ft = 4'd4; else if (j < 12) ft = 4'd5; else ft = 4'd6;
      sb.push_back(mk(st, stk, ft));
      cycle();
      obs = {state, health_ok, alarm, sticky, fail_total};
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL accumulate j=%0d got st=%b ok=%b al=%b stk=%b ft=%0d required st=%b ok=%b al=%b stk=%b ft=%0d",
                 j, obs.st, obs.hok, obs.alm, obs.stk, obs.ft, want.st, want.hok, want.alm, want.stk, want.ft);
      end
    end
  endtask

  task automatic test_saturate();
    int n;
    int f;
    for (int j = 0; j < 41; j++) begin
      clear = 1'b0;
      rst = (j == 40);
      err_in = (j < 40 && (j % 4) < 2) ? 4'b1111 : 4'b0000;
      n = (j >= 2) ? ((j - 2) / 4 + 1) : 0;
      f = 6 + 4 * n;
      if (f > 15) f = 15;
      if (j == 40) sb.push_back(mk(2'b00, 4'b0000, 4'd0));
      else sb.push_back(mk(2'b11, (j >= 2) ? 4'b1111 : 4'b0111, 4'(f)));
      cycle();
      obs = {state, health_ok, alarm, sticky, fail_total};
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL saturate j=%0d got st=%b ok=%b al=%b stk=%b ft=%0d required st=%b ok=%b al=%b stk=%b ft=%0d",
                 j, obs.st, obs.hok, obs.alm, obs.stk, obs.ft, want.st, want.hok, want.alm, want.stk, want.ft);
      end
    end
  endtask

  initial begin
    rst = 1'b1; err_in = 4'h0; clear = 1'b0;
    test_reset();
    test_warmup_ignore();
    test_degraded_window();
    test_expiry_coincide();
    test_failed_direct();
    test_clear_failed();
    test_accumulate();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
